// File: rtl/servo_pwm_driver_if.sv
// -----------------------------------------------------------------------------
// servo_pwm_driver_if
//
// Link between the angle-sweep controller and the servo PWM driver.
//
// Signals:
//   servo_angle      [7:0]  angle code (8'h00 = -90 deg, 8'h80 = centre,
//                           8'hFF = +90 deg), driven by the sweep controller
//   pwm_en                  1 = emit pulses, 0 = keep the servo pin low
//   servo_cycle_done        one-clock strobe from the driver at each PWM
//                           period boundary
//
// Modports:
//   master  - sweep controller side (drives angle/enable, watches done)
//   slave   - PWM driver side (samples angle/enable, raises done)
// -----------------------------------------------------------------------------
interface servo_pwm_driver_if;
  logic [7:0] servo_angle;
  logic       pwm_en;
  logic       servo_cycle_done;

  modport master (
    output servo_angle,
    output pwm_en,
    input  servo_cycle_done
  );

  modport slave (
    input  servo_angle,
    input  pwm_en,
    output servo_cycle_done
  );
endinterface

// File: rtl/servo_pwm_driver.sv
// -----------------------------------------------------------------------------
// servo_pwm_driver
//
// Turns an 8-bit servo angle code into a hobby-servo pulse train and reports
// each completed PWM period back to the sweep controller.
//
//   pulse_ticks = MIN_PULSE_US + ((servo_angle * SPAN_US) >> 8)
//
// The angle and the enable are sampled only at a period start, so a pulse
// width never changes while the pulse is on the pin.
//
// Parameters:
//   TICK_DIV      clocks per timing tick (>= 1)
//   PERIOD_US     PWM period in ticks
//   MIN_PULSE_US  pulse width in ticks for angle code 8'h00
//   SPAN_US       extra pulse width in ticks for full-scale angle (x256/256)
//   MIN_PULSE_US + SPAN_US must be below PERIOD_US (not checked here).
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   sweep_if  slave modport: servo_angle / pwm_en in, servo_cycle_done out
//   pwm_out   out  servo control pulse (registered)
//
// Timing:
//   - First period starts on the first edge after rst_n releases; that start
//     raises no done strobe.
//   - Every later period start raises servo_cycle_done for one clock and, if
//     a pulse is due, raises pwm_out on the same edge.
//   - Period = PERIOD_US * TICK_DIV clocks, high time = pulse_ticks * TICK_DIV.
//   - All outputs come straight from flops.
// -----------------------------------------------------------------------------
module servo_pwm_driver #(
  parameter int TICK_DIV     = 50,
  parameter int PERIOD_US    = 20000,
  parameter int MIN_PULSE_US = 1000,
  parameter int SPAN_US      = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  servo_pwm_driver_if.slave        sweep_if,
  output logic                     pwm_out
);

  // Counter widths, never narrower than one bit.
  localparam int CLK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int TICK_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  // Product is held at full width (8 + width(SPAN_US)) so nothing is lost
  // before the >> 8.
  localparam int SPAN_W = (SPAN_US > 0) ? $clog2(SPAN_US + 1) : 1;
  localparam int PROD_W = 8 + SPAN_W;

  localparam logic [CLK_W-1:0]  CLK_LAST  = CLK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD_US - 1);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2
  } state_t;

  state_t              state_q;
  logic [CLK_W-1:0]    clk_cnt_q,  clk_cnt_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [TICK_W-1:0]   pulse_q;
  logic                en_q;
  logic                pwm_q;
  logic                done_q;

  logic [PROD_W-1:0]   prod_s;
  logic [PROD_W-1:0]   prod_shr_s;
  logic [TICK_W-1:0]   pulse_calc_s;
  logic                fire_s;
  logic                tick_wrap_s;
  logic                period_end_s;
  logic                pulse_end_s;
  logic                start_s;

  // Pulse width from the live angle; only captured at a period start.
  always_comb begin
    prod_s       = PROD_W'(sweep_if.servo_angle) * PROD_W'(SPAN_US);
    prod_shr_s   = prod_s >> 8;
    pulse_calc_s = TICK_W'(MIN_PULSE_US) + TICK_W'(prod_shr_s);
    // A zero-width pulse must never reach the pin, not even for one clock.
    fire_s       = sweep_if.pwm_en && (pulse_calc_s != {TICK_W{1'b0}});
  end

  // Tick / period / pulse boundary decode and counter next-state.
  always_comb begin
    tick_wrap_s  = (clk_cnt_q == CLK_LAST);
    period_end_s = tick_wrap_s && (tick_cnt_q == TICK_LAST);
    pulse_end_s  = tick_wrap_s && (tick_cnt_q == (pulse_q - TICK_W'(1)));
    // START lasts exactly one clock, so its exit edge is a period start too.
    start_s      = (state_q == ST_START) || period_end_s;

    clk_cnt_d  = clk_cnt_q;
    tick_cnt_d = tick_cnt_q;
    if (start_s) begin
      clk_cnt_d  = {CLK_W{1'b0}};
      tick_cnt_d = {TICK_W{1'b0}};
    end else if (tick_wrap_s) begin
      clk_cnt_d  = {CLK_W{1'b0}};
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end else begin
      clk_cnt_d  = clk_cnt_q + CLK_W'(1);
      tick_cnt_d = tick_cnt_q;
    end
  end

  // Clock-divider and period tick counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_q  <= {CLK_W{1'b0}};
      tick_cnt_q <= {TICK_W{1'b0}};
    end else begin
      clk_cnt_q  <= clk_cnt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Pulse FSM with registered pin and done strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_START;
      pulse_q <= {TICK_W{1'b0}};
      en_q    <= 1'b0;
      pwm_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // The START exit opens the first period but completes none.
      done_q <= period_end_s && (state_q != ST_START);
      if (start_s) begin
        pulse_q <= pulse_calc_s;
        en_q    <= sweep_if.pwm_en;
        // Pin rises on the same edge as done so the sweep controller sees
        // the strobe and the new pulse together.
        if (fire_s) begin
          state_q <= ST_HIGH;
          pwm_q   <= 1'b1;
        end else begin
          state_q <= ST_LOW;
          pwm_q   <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_HIGH: begin
            // en_q is always 1 while HIGH; also gating on it means a
            // disturbed enable register can only force the pin low.
            if (pulse_end_s || !en_q) begin
              state_q <= ST_LOW;
              pwm_q   <= 1'b0;
            end else begin
              state_q <= ST_HIGH;
              pwm_q   <= 1'b1;
            end
          end
          ST_LOW: begin
            state_q <= ST_LOW;
            pwm_q   <= 1'b0;
          end
          default: begin
            state_q <= ST_LOW;
            pwm_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pwm_out                   = pwm_q;
  assign sweep_if.servo_cycle_done = done_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_driver
//
// Three driver instances sharing clock and reset:
//   A: TICK_DIV=1, PERIOD=600, MIN=100, SPAN=256  (pulse = 100 + angle)
//   B: TICK_DIV=3, same otherwise                  (pulse = 3*(100 + angle))
//   C: TICK_DIV=1, MIN=0                           (pulse = angle)
// Periods are measured between done strobes; inputs written during a done
// cycle take effect one period later.
// -----------------------------------------------------------------------------
module tb_servo_pwm_driver;

  localparam int LIMIT = 4000;

  logic clk;
  logic rst_n;
  logic pwm_a, pwm_b, pwm_c;

  servo_pwm_driver_if a_if();
  servo_pwm_driver_if b_if();
  servo_pwm_driver_if c_if();

  servo_pwm_driver #(.TICK_DIV(1), .PERIOD_US(600), .MIN_PULSE_US(100), .SPAN_US(256))
    dut_a (.clk(clk), .rst_n(rst_n), .sweep_if(a_if), .pwm_out(pwm_a));
  servo_pwm_driver #(.TICK_DIV(3), .PERIOD_US(600), .MIN_PULSE_US(100), .SPAN_US(256))
    dut_b (.clk(clk), .rst_n(rst_n), .sweep_if(b_if), .pwm_out(pwm_b));
  servo_pwm_driver #(.TICK_DIV(1), .PERIOD_US(600), .MIN_PULSE_US(0), .SPAN_US(256))
    dut_c (.clk(clk), .rst_n(rst_n), .sweep_if(c_if), .pwm_out(pwm_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         sel;
    logic [7:0] angle;
    logic       en;
    bit         chg;
    int         chg_cyc;
    logic [7:0] chg_angle;
    logic       chg_en;
    int         exp_hi;
    int         exp_len;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pwm_of(input int sel);
    case (sel)
      0:       return pwm_a;
      1:       return pwm_b;
      default: return pwm_c;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return a_if.servo_cycle_done;
      1:       return b_if.servo_cycle_done;
      default: return c_if.servo_cycle_done;
    endcase
  endfunction

  task automatic set_inputs(input int sel, input logic [7:0] ang, input logic en);
    case (sel)
      0: begin a_if.servo_angle = ang; a_if.pwm_en = en; end
      1: begin b_if.servo_angle = ang; b_if.pwm_en = en; end
      default: begin c_if.servo_angle = ang; c_if.pwm_en = en; end
    endcase
  endtask

  // Wait (bounded) until a negedge sample shows done for the chosen DUT.
  task automatic wait_done(input int sel);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_of(sel) && n < LIMIT);
    check("wait_done", int'(done_of(sel)), 1);
  endtask

  // Count samples from the current cycle up to (not including) the next
  // done cycle; optionally change inputs after chg_cyc samples.
  task automatic measure(input int sel, input bit chg, input int chg_cyc,
                         input logic [7:0] chg_angle, input logic chg_en,
                         output int hi, output int len);
    hi  = 0;
    len = 0;
    do begin
      if (pwm_of(sel)) hi++;
      len++;
      if (chg && len == chg_cyc) set_inputs(sel, chg_angle, chg_en);
      @(negedge clk);
    end while (!done_of(sel) && len < LIMIT);
  endtask

  initial begin
    int hi, len, prev_sel;

    tbl[0]  = '{0, 8'h80, 1'b1, 1'b1, 50, 8'hFF, 1'b1, 228, 600};
    tbl[1]  = '{0, 8'hFF, 1'b1, 1'b0, 0,  8'h00, 1'b0, 355, 600};
    tbl[2]  = '{0, 8'h00, 1'b1, 1'b0, 0,  8'h00, 1'b0, 355, 600};
    tbl[3]  = '{0, 8'hFF, 1'b1, 1'b0, 0,  8'h00, 1'b0, 100, 600};
    tbl[4]  = '{0, 8'hFF, 1'b1, 1'b1, 50, 8'hFF, 1'b0, 355, 600};
    tbl[5]  = '{0, 8'hFF, 1'b0, 1'b0, 0,  8'h00, 1'b0, 0,   600};
    tbl[6]  = '{0, 8'hFF, 1'b1, 1'b0, 0,  8'h00, 1'b0, 0,   600};
    tbl[7]  = '{0, 8'h80, 1'b1, 1'b0, 0,  8'h00, 1'b0, 355, 600};
    tbl[8]  = '{0, 8'h80, 1'b1, 1'b0, 0,  8'h00, 1'b0, 228, 600};
    tbl[9]  = '{1, 8'hFF, 1'b1, 1'b0, 0,  8'h00, 1'b0, 300, 1800};
    tbl[10] = '{1, 8'hFF, 1'b1, 1'b0, 0,  8'h00, 1'b0, 1065, 1800};
    tbl[11] = '{1, 8'h00, 1'b1, 1'b0, 0,  8'h00, 1'b0, 1065, 1800};
    tbl[12] = '{2, 8'h01, 1'b1, 1'b0, 0,  8'h00, 1'b0, 0,   600};
    tbl[13] = '{2, 8'h00, 1'b1, 1'b0, 0,  8'h00, 1'b0, 1,   600};
    tbl[14] = '{2, 8'h00, 1'b1, 1'b0, 0,  8'h00, 1'b0, 0,   600};

    // Reset state
    rst_n = 1'b0;
    set_inputs(0, 8'h80, 1'b1);
    set_inputs(1, 8'h00, 1'b1);
    set_inputs(2, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    check("reset_pwm_a",  int'(pwm_a), 0);
    check("reset_done_a", int'(a_if.servo_cycle_done), 0);
    check("reset_pwm_c",  int'(pwm_c), 0);

    // First period after release: pulse on first edge, no done strobe
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_pwm",  int'(pwm_a), 1);
    check("first_edge_done", int'(a_if.servo_cycle_done), 0);
    measure(0, 1'b0, 0, 8'h00, 1'b0, hi, len);
    check("first_high", hi, 228);
    check("first_len",  len, 600);
    check("first_done_pwm", int'(pwm_a), 1);

    // Table-driven periods
    prev_sel = 0;
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].sel != prev_sel) wait_done(tbl[i].sel);
      prev_sel = tbl[i].sel;
      set_inputs(tbl[i].sel, tbl[i].angle, tbl[i].en);
      measure(tbl[i].sel, tbl[i].chg, tbl[i].chg_cyc, tbl[i].chg_angle,
              tbl[i].chg_en, hi, len);
      check($sformatf("vec%0d_high", i), hi, tbl[i].exp_hi);
      check($sformatf("vec%0d_len", i),  len, tbl[i].exp_len);
    end

    // Asynchronous reset in the middle of a pulse
    wait_done(0);
    repeat (100) @(negedge clk);
    check("mid_pulse_pwm", int'(pwm_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm",  int'(pwm_a), 0);
    check("async_rst_done", int'(a_if.servo_cycle_done), 0);
    @(negedge clk);
    @(negedge clk);
    check("held_rst_pwm", int'(pwm_a), 0);
    set_inputs(0, 8'hFF, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerelease_pwm",  int'(pwm_a), 1);
    check("rerelease_done", int'(a_if.servo_cycle_done), 0);
    measure(0, 1'b0, 0, 8'h00, 1'b0, hi, len);
    check("rerelease_high", hi, 355);
    check("rerelease_len",  len, 600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
